// File: rtl/cellrv32_package.sv
`default_nettype none
// ============================================================================
// Module      : cellrv32_package
// Description : Shared types and constants for the CELLRV32 vector
//               coprocessor front end. Holds the instruction structures
//               exchanged between the vector instruction queue, the renamer
//               and the execution / memory-issue queues, plus the renamer's
//               in-flight bookkeeping record.
//               Register index fields are VREG_W_C wide and ticket fields
//               VTICKET_W_C wide; the renamer uses the low bits it needs.
// Revision    : 1.0 - initial release
// ============================================================================
package cellrv32_package;

    localparam int VREG_W_C    = 7;
    localparam int VTICKET_W_C = 8;

    localparam logic [2:0] VOP_LOAD_C  = 3'b000;
    localparam logic [2:0] VOP_STORE_C = 3'b010;

    typedef struct packed {
        logic [31:0]         data1;
        logic [31:0]         data2;
        logic [VREG_W_C-1:0] dst;
        logic [VREG_W_C-1:0] src1;
        logic [VREG_W_C-1:0] src2;
        logic [2:0]          microop;
        logic [1:0]          fu;
        logic                use_mask;
        logic                reconfigure;
    } to_vector;

    typedef struct packed {
        logic [31:0]            data1;
        logic [31:0]            data2;
        logic [VREG_W_C-1:0]    dst;
        logic [VREG_W_C-1:0]    src1;
        logic [VREG_W_C-1:0]    src2;
        logic [VREG_W_C-1:0]    mask_src;
        logic                   dst_iszero;
        logic                   src1_iszero;
        logic                   src2_iszero;
        logic [2:0]             microop;
        logic [1:0]             fu;
        logic                   use_mask;
        logic                   reconfigure;
        logic [1:0]             lock;
        logic [VTICKET_W_C-1:0] ticket;
    } remapped_v_instr;

    typedef struct packed {
        logic [31:0]            data1;
        logic [31:0]            data2;
        logic [VREG_W_C-1:0]    dst;
        logic [VREG_W_C-1:0]    src1;
        logic [VREG_W_C-1:0]    src2;
        logic [VREG_W_C-1:0]    mask_src;
        logic                   dst_iszero;
        logic [2:0]             microop;
        logic                   use_mask;
        logic                   reconfigure;
        logic [VTICKET_W_C-1:0] ticket;
        logic [VTICKET_W_C-1:0] last_ticket_src1;
        logic [VTICKET_W_C-1:0] last_ticket_src2;
    } memory_remapped_v_instr;

    // One entry per issued instruction, retired strictly in order.
    typedef struct packed {
        logic [VTICKET_W_C-1:0] ticket;
        logic [VREG_W_C-1:0]    old_phys;
        logic                   has_old;
    } vrename_inflight_t;

endpackage
`default_nettype wire

// File: rtl/cellrv32_vrename_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cellrv32_vrename_fifo
// Description : Generic synchronous circular FIFO with optional fill-on-init.
//               When INIT_FILL is set, reset and i_init load the FIFO full
//               with the sequence INIT_BASE, INIT_BASE+1, ... (used for the
//               physical register free list); otherwise they empty it.
//               DEPTH need not be a power of two.
// Ports       : clk_i, rstn_i (async active-low)
//               i_init             - reload to the initial contents
//               i_push, i_data     - write one entry
//               i_pop              - drop the head entry
//               o_data             - head entry (valid when !o_empty)
//               o_full, o_empty    - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module cellrv32_vrename_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit INIT_FILL = 1'b0,
    parameter int INIT_BASE = 0
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             i_init,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign o_full    = (r_count == c_cnt_w'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    // A push into a full FIFO is accepted only when the head leaves this cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= INIT_FILL ? WIDTH'(INIT_BASE + i) : '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= INIT_FILL ? c_cnt_w'(DEPTH) : '0;
        end else if (i_init) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= INIT_FILL ? WIDTH'(INIT_BASE + i) : '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= INIT_FILL ? c_cnt_w'(DEPTH) : '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cellrv32_vrename.sv
`default_nettype none
// ============================================================================
// Module      : cellrv32_vrename
// Description : Vector register renamer. Maps architectural vector registers
//               onto a larger physical file through a RAT and a free list,
//               hands out in-order tickets, and returns superseded physical
//               registers to the free list on in-order retirement.
//               Optional feature macro: CELLRV32_VRENAME_LAST_PRODUCER_EN
//               keeps a per-architectural-register last producer ticket for
//               the memory-issue path.
// Ports       : clk_i, rstn_i (async active-low)
//               valid_in/instr_in/pop_instr   - instruction queue side
//               valid_o/instr_out/ready_i     - execution queue side
//               m_valid_o/m_instr_out/m_ready_i - memory queue (loads/stores)
//               retire_valid_i/retire_ticket_i - in-order retirement
//               retire_err_o                  - sticky out-of-order retire
//               is_idle_o                     - nothing pending or in flight
// Revision    : 1.0 - initial release
// ============================================================================
module cellrv32_vrename
    import cellrv32_package::*;
#(
    parameter int ARCH_REGS    = 32,
    parameter int PHYS_REGS    = 48,
    parameter int VECTOR_LANES = 8,
    parameter int TICKET_BITS  = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   valid_in,
    input  to_vector               instr_in,
    output logic                   pop_instr,
    output logic                   valid_o,
    output remapped_v_instr        instr_out,
    input  logic                   ready_i,
    output logic                   m_valid_o,
    output memory_remapped_v_instr m_instr_out,
    input  logic                   m_ready_i,
    input  logic                   retire_valid_i,
    input  logic [TICKET_BITS-1:0] retire_ticket_i,
    output logic                   retire_err_o,
    output logic                   is_idle_o
);

    localparam int c_areg_w     = $clog2(ARCH_REGS);
    localparam int c_preg_w     = $clog2(PHYS_REGS);
    localparam int c_free_depth = PHYS_REGS - ARCH_REGS;
    localparam int c_inf_depth  = (1 << TICKET_BITS) - 1;
    localparam int c_inf_w      = $bits(vrename_inflight_t);
    localparam int c_unused_lanes = VECTOR_LANES;
    localparam logic [TICKET_BITS-1:0] c_ticket_max   = '1;
    localparam logic [TICKET_BITS-1:0] c_ticket_first = TICKET_BITS'(1);

    logic [c_preg_w-1:0]    r_rat [ARCH_REGS];
    logic [TICKET_BITS-1:0] r_next_ticket;
    logic                   r_retire_err;

    logic [c_areg_w-1:0]    w_dst_a;
    logic [c_areg_w-1:0]    w_src1_a;
    logic [c_areg_w-1:0]    w_src2_a;
    logic                   w_is_load;
    logic                   w_is_store;
    logic                   w_is_mem;
    logic                   w_reconf;
    logic                   w_alloc;
    logic                   w_fire;
    logic                   w_retire_ok;

    logic [c_preg_w-1:0]    w_fl_head;
    logic                   w_fl_empty;
    logic                   w_fl_full;
    logic                   w_fl_push;

    vrename_inflight_t      w_inf_head;
    vrename_inflight_t      w_inf_push_data;
    logic                   w_inf_full;
    logic                   w_inf_empty;

    logic [VREG_W_C-1:0]    w_dst_phys;
    logic [VREG_W_C-1:0]    w_src1_phys;
    logic [VREG_W_C-1:0]    w_src2_phys;
    logic [VREG_W_C-1:0]    w_mask_phys;
    logic [VREG_W_C-1:0]    w_old_phys;
    logic [1:0]             w_lock;
    logic [VTICKET_W_C-1:0] w_ticket_ext;
    logic [VTICKET_W_C-1:0] w_last_src1;
    logic [VTICKET_W_C-1:0] w_last_src2;
    logic                   w_unused_bits;

    // ------------------------------------------------------------------
    // Decode and issue condition
    // ------------------------------------------------------------------
    assign w_dst_a    = instr_in.dst[c_areg_w-1:0];
    assign w_src1_a   = instr_in.src1[c_areg_w-1:0];
    assign w_src2_a   = instr_in.src2[c_areg_w-1:0];
    assign w_is_load  = (instr_in.microop == VOP_LOAD_C);
    assign w_is_store = (instr_in.microop == VOP_STORE_C);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_reconf   = instr_in.reconfigure;
    assign w_alloc    = !w_is_store && !w_reconf;

    // Reconfigure rebuilds the RAT and free list, so it may only proceed
    // once nothing older can still return registers.
    assign w_fire = valid_in && ready_i
                 && (!w_is_mem || m_ready_i)
                 && !w_inf_full
                 && (!w_alloc || !w_fl_empty)
                 && (!w_reconf || w_inf_empty);

    assign w_retire_ok = retire_valid_i && !w_inf_empty
                      && (w_inf_head.ticket == VTICKET_W_C'(retire_ticket_i));

    // All RAT reads see the mapping before this cycle's update.
    assign w_old_phys   = VREG_W_C'(r_rat[w_dst_a]);
    assign w_dst_phys   = w_alloc ? VREG_W_C'(w_fl_head) : w_old_phys;
    assign w_src1_phys  = VREG_W_C'(r_rat[w_src1_a]);
    assign w_src2_phys  = VREG_W_C'(r_rat[w_src2_a]);
    assign w_mask_phys  = VREG_W_C'(r_rat[0]);
    assign w_ticket_ext = VTICKET_W_C'(r_next_ticket);

    always_comb begin
        w_lock = 2'b00;
        if (w_is_load) begin
            w_lock = 2'b11;
        end else if (w_is_store) begin
            w_lock = 2'b01;
        end
        if (w_reconf) begin
            w_lock = 2'b00;
        end
    end

    assign pop_instr    = w_fire;
    assign valid_o      = w_fire;
    assign m_valid_o    = w_fire && w_is_mem;
    assign retire_err_o = r_retire_err;
    assign is_idle_o    = !valid_in && w_inf_empty;

    always_comb begin
        instr_out             = '0;
        instr_out.data1       = instr_in.data1;
        instr_out.data2       = instr_in.data2;
        instr_out.dst         = w_dst_phys;
        instr_out.src1        = w_src1_phys;
        instr_out.src2        = w_src2_phys;
        instr_out.mask_src    = w_mask_phys;
        instr_out.dst_iszero  = w_is_store;
        instr_out.src1_iszero = 1'b0;
        instr_out.src2_iszero = 1'b0;
        instr_out.microop     = instr_in.microop;
        instr_out.fu          = instr_in.fu;
        instr_out.use_mask    = instr_in.use_mask;
        instr_out.reconfigure = instr_in.reconfigure;
        instr_out.lock        = w_lock;
        instr_out.ticket      = w_ticket_ext;
    end

    always_comb begin
        m_instr_out                  = '0;
        m_instr_out.data1            = instr_in.data1;
        m_instr_out.data2            = instr_in.data2;
        m_instr_out.dst              = w_dst_phys;
        m_instr_out.src1             = w_src1_phys;
        m_instr_out.src2             = w_src2_phys;
        m_instr_out.mask_src         = w_mask_phys;
        m_instr_out.dst_iszero       = w_is_store;
        m_instr_out.microop          = instr_in.microop;
        m_instr_out.use_mask         = instr_in.use_mask;
        m_instr_out.reconfigure      = instr_in.reconfigure;
        m_instr_out.ticket           = w_ticket_ext;
        m_instr_out.last_ticket_src1 = w_last_src1;
        m_instr_out.last_ticket_src2 = w_last_src2;
    end

    // ------------------------------------------------------------------
    // Free list and in-flight FIFO
    // ------------------------------------------------------------------
    assign w_fl_push = w_retire_ok && w_inf_head.has_old;

    cellrv32_vrename_fifo #(
        .WIDTH     (c_preg_w),
        .DEPTH     (c_free_depth),
        .INIT_FILL (1'b1),
        .INIT_BASE (ARCH_REGS)
    ) u_free_list (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .i_init  (w_fire && w_reconf),
        .i_push  (w_fl_push),
        .i_data  (w_inf_head.old_phys[c_preg_w-1:0]),
        .i_pop   (w_fire && w_alloc),
        .o_data  (w_fl_head),
        .o_full  (w_fl_full),
        .o_empty (w_fl_empty)
    );

    always_comb begin
        w_inf_push_data          = '0;
        w_inf_push_data.ticket   = w_ticket_ext;
        w_inf_push_data.old_phys = w_old_phys;
        w_inf_push_data.has_old  = w_alloc;
    end

    cellrv32_vrename_fifo #(
        .WIDTH     (c_inf_w),
        .DEPTH     (c_inf_depth),
        .INIT_FILL (1'b0),
        .INIT_BASE (0)
    ) u_inflight (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .i_init  (1'b0),
        .i_push  (w_fire),
        .i_data  (w_inf_push_data),
        .i_pop   (w_retire_ok),
        .o_data  (w_inf_head),
        .o_full  (w_inf_full),
        .o_empty (w_inf_empty)
    );

    // ------------------------------------------------------------------
    // RAT, ticket counter, sticky retire error
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_rat[i] <= c_preg_w'(i);
            end
            r_next_ticket <= c_ticket_first;
            r_retire_err  <= 1'b0;
        end else begin
            if (w_fire) begin
                if (w_reconf) begin
                    for (int i = 0; i < ARCH_REGS; i++) begin
                        r_rat[i] <= c_preg_w'(i);
                    end
                    r_next_ticket <= c_ticket_first;
                end else begin
                    if (w_alloc) begin
                        r_rat[w_dst_a] <= w_fl_head;
                    end
                    // Ticket 0 means "no producer", so the count wraps to 1.
                    r_next_ticket <= (r_next_ticket == c_ticket_max)
                                   ? c_ticket_first
                                   : r_next_ticket + TICKET_BITS'(1);
                end
            end
            if (retire_valid_i && !w_retire_ok) begin
                r_retire_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Last producer tracking for the memory-issue path
    // ------------------------------------------------------------------
`ifdef CELLRV32_VRENAME_LAST_PRODUCER_EN
    logic [TICKET_BITS-1:0] r_last_prod [ARCH_REGS];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_last_prod[i] <= '0;
            end
        end else if (w_fire) begin
            if (w_reconf) begin
                for (int i = 0; i < ARCH_REGS; i++) begin
                    r_last_prod[i] <= '0;
                end
            end else if (!w_is_store) begin
                r_last_prod[w_dst_a] <= r_next_ticket;
            end
        end
    end

    // An empty entry means no older producer is known; fall back to own ticket.
    assign w_last_src1 = (r_last_prod[w_src1_a] == '0) ? w_ticket_ext
                       : VTICKET_W_C'(r_last_prod[w_src1_a]);
    assign w_last_src2 = (r_last_prod[w_src2_a] == '0) ? w_ticket_ext
                       : VTICKET_W_C'(r_last_prod[w_src2_a]);
`else
    assign w_last_src1 = w_ticket_ext;
    assign w_last_src2 = w_ticket_ext;
`endif

    assign w_unused_bits = ^{instr_in.dst[VREG_W_C-1:c_areg_w],
                             instr_in.src1[VREG_W_C-1:c_areg_w],
                             instr_in.src2[VREG_W_C-1:c_areg_w],
                             w_inf_head.old_phys[VREG_W_C-1:c_preg_w],
                             w_fl_full, c_unused_lanes[0]};

endmodule
`default_nettype wire

// File: tb/tb_cellrv32_vrename.sv
`default_nettype none
// ============================================================================
// Module      : tb_cellrv32_vrename
// Description : Directed self-checking bench for cellrv32_vrename. A second
//               instance with TICKET_BITS=5 shares the inputs so the free
//               list can be drained without hitting the in-flight limit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cellrv32_vrename;
    import cellrv32_package::*;

    localparam logic [2:0] c_alu = 3'b001;

    logic                   clk = 1'b0;
    logic                   rstn_i;
    logic                   valid_in;
    to_vector               instr_in;
    logic                   ready_i;
    logic                   m_ready_i;
    logic                   retire_valid_i;
    logic [3:0]             retire_ticket_i;
    logic [4:0]             retire_ticket5;

    logic                   pop_instr, valid_o, m_valid_o, retire_err_o, is_idle_o;
    remapped_v_instr        instr_out;
    memory_remapped_v_instr m_instr_out;

    logic                   pop5, valid5, m_valid5, err5, idle5;
    remapped_v_instr        instr_out5;
    memory_remapped_v_instr m_instr_out5;

    int n_vec = 0;
    int n_err = 0;

    assign retire_ticket5 = {1'b0, retire_ticket_i};

    always #5 clk = ~clk;

    cellrv32_vrename u_dut (
        .clk_i           (clk),
        .rstn_i          (rstn_i),
        .valid_in        (valid_in),
        .instr_in        (instr_in),
        .pop_instr       (pop_instr),
        .valid_o         (valid_o),
        .instr_out       (instr_out),
        .ready_i         (ready_i),
        .m_valid_o       (m_valid_o),
        .m_instr_out     (m_instr_out),
        .m_ready_i       (m_ready_i),
        .retire_valid_i  (retire_valid_i),
        .retire_ticket_i (retire_ticket_i),
        .retire_err_o    (retire_err_o),
        .is_idle_o       (is_idle_o)
    );

    cellrv32_vrename #(.TICKET_BITS(5)) u_dut_t5 (
        .clk_i           (clk),
        .rstn_i          (rstn_i),
        .valid_in        (valid_in),
        .instr_in        (instr_in),
        .pop_instr       (pop5),
        .valid_o         (valid5),
        .instr_out       (instr_out5),
        .ready_i         (ready_i),
        .m_valid_o       (m_valid5),
        .m_instr_out     (m_instr_out5),
        .m_ready_i       (m_ready_i),
        .retire_valid_i  (retire_valid_i),
        .retire_ticket_i (retire_ticket5),
        .retire_err_o    (err5),
        .is_idle_o       (idle5)
    );

    task automatic set_op(input logic [2:0] op, input int d, input int s1,
                          input int s2, input logic rc);
        instr_in             = '0;
        instr_in.microop     = op;
        instr_in.dst         = 7'(d);
        instr_in.src1        = 7'(s1);
        instr_in.src2        = 7'(s2);
        instr_in.data1       = 32'hA5A5_0000 + 32'(d);
        instr_in.reconfigure = rc;
        valid_in             = 1'b1;
    endtask

    task automatic apply_reset();
        valid_in       = 1'b0;
        retire_valid_i = 1'b0;
        retire_ticket_i = '0;
        ready_i        = 1'b1;
        m_ready_i      = 1'b1;
        rstn_i         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        valid_in = 1'b0; retire_valid_i = 1'b0; retire_ticket_i = '0;
        ready_i = 1'b1; m_ready_i = 1'b1; instr_in = '0;
        rstn_i = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid_o: got %0b exp 0", valid_o); end
        n_vec++; if (pop_instr !== 1'b0) begin n_err++; $display("FAIL reset_pop: got %0b exp 0", pop_instr); end
        n_vec++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %0b exp 0", m_valid_o); end
        n_vec++; if (retire_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b exp 0", retire_err_o); end
        n_vec++; if (is_idle_o !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %0b exp 1", is_idle_o); end
        n_vec++; if (idle5 !== 1'b1) begin n_err++; $display("FAIL reset_idle_t5: got %0b exp 1", idle5); end
        rstn_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_rename();
        apply_reset();
        set_op(c_alu, 3, 3, 7, 1'b0);
        #1;
        n_vec++; if (pop_instr !== 1'b1) begin n_err++; $display("FAIL basic_pop: got %0b exp 1", pop_instr); end
        n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b exp 1", valid_o); end
        n_vec++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_m_valid: got %0b exp 0", m_valid_o); end
        n_vec++; if (instr_out.dst !== 7'd32) begin n_err++; $display("FAIL basic_dst: got %0d exp 32", instr_out.dst); end
        n_vec++; if (instr_out.src1 !== 7'd3) begin n_err++; $display("FAIL basic_src1: got %0d exp 3", instr_out.src1); end
        n_vec++; if (instr_out.src2 !== 7'd7) begin n_err++; $display("FAIL basic_src2: got %0d exp 7", instr_out.src2); end
        n_vec++; if (instr_out.ticket !== 8'd1) begin n_err++; $display("FAIL basic_ticket: got %0d exp 1", instr_out.ticket); end
        n_vec++; if (instr_out.lock !== 2'b00) begin n_err++; $display("FAIL basic_lock: got %0d exp 0", instr_out.lock); end
        n_vec++; if (instr_out.data1 !== 32'hA5A5_0003) begin n_err++; $display("FAIL basic_data1: got %h exp a5a50003", instr_out.data1); end
        n_vec++; if (is_idle_o !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %0b exp 0", is_idle_o); end
        @(negedge clk);
        set_op(c_alu, 9, 3, 3, 1'b0);
        #1;
        n_vec++; if (instr_out.src1 !== 7'd32) begin n_err++; $display("FAIL basic_src1_renamed: got %0d exp 32", instr_out.src1); end
        n_vec++; if (instr_out.src2 !== 7'd32) begin n_err++; $display("FAIL basic_src2_renamed: got %0d exp 32", instr_out.src2); end
        n_vec++; if (instr_out.dst !== 7'd33) begin n_err++; $display("FAIL basic_dst2: got %0d exp 33", instr_out.dst); end
        n_vec++; if (instr_out.ticket !== 8'd2) begin n_err++; $display("FAIL basic_ticket2: got %0d exp 2", instr_out.ticket); end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic test_freelist_empty();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            set_op(c_alu, (i == 0) ? 3 : i + 10, 1, 2, 1'b0);
            #1;
            n_vec++; if (pop5 !== 1'b1) begin n_err++; $display("FAIL fl_pop[%0d]: got %0b exp 1", i, pop5); end
            n_vec++; if (instr_out5.dst !== 7'(32 + i)) begin n_err++; $display("FAIL fl_dst[%0d]: got %0d exp %0d", i, instr_out5.dst, 32 + i); end
            @(negedge clk);
        end
        set_op(c_alu, 20, 1, 2, 1'b0);
        retire_valid_i = 1'b1; retire_ticket_i = 4'd1;
        #1;
        n_vec++; if (pop5 !== 1'b0) begin n_err++; $display("FAIL fl_stall_empty: got %0b exp 0", pop5); end
        @(negedge clk);
        retire_valid_i = 1'b0;
        #1;
        n_vec++; if (pop5 !== 1'b1) begin n_err++; $display("FAIL fl_refill_pop: got %0b exp 1", pop5); end
        n_vec++; if (instr_out5.dst !== 7'd3) begin n_err++; $display("FAIL fl_refill_dst: got %0d exp 3", instr_out5.dst); end
        n_vec++; if (instr_out5.ticket !== 8'd17) begin n_err++; $display("FAIL fl_refill_ticket: got %0d exp 17", instr_out5.ticket); end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic test_fifo_full();
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            set_op(c_alu, 1, 2, 3, 1'b0);
            #1;
            n_vec++; if (pop_instr !== 1'b1) begin n_err++; $display("FAIL full_pop[%0d]: got %0b exp 1", i, pop_instr); end
            n_vec++; if (instr_out.ticket !== 8'(i + 1)) begin n_err++; $display("FAIL full_ticket[%0d]: got %0d exp %0d", i, instr_out.ticket, i + 1); end
            @(negedge clk);
        end
        set_op(c_alu, 1, 2, 3, 1'b0);
        retire_valid_i = 1'b1; retire_ticket_i = 4'd1;
        #1;
        n_vec++; if (pop_instr !== 1'b0) begin n_err++; $display("FAIL full_stall: got %0b exp 0", pop_instr); end
        @(negedge clk);
        retire_valid_i = 1'b0;
        #1;
        n_vec++; if (pop_instr !== 1'b1) begin n_err++; $display("FAIL full_resume_pop: got %0b exp 1", pop_instr); end
        n_vec++; if (instr_out.ticket !== 8'd1) begin n_err++; $display("FAIL full_wrap_ticket: got %0d exp 1", instr_out.ticket); end
        n_vec++; if (instr_out.dst !== 7'd47) begin n_err++; $display("FAIL full_resume_dst: got %0d exp 47", instr_out.dst); end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic test_store_after_load();
        logic [7:0] exp_lt1;
        logic [7:0] exp_lt2;
        logic [7:0] exp_load_lt1;
`ifdef CELLRV32_VRENAME_LAST_PRODUCER_EN
        exp_lt1 = 8'd2; exp_lt2 = 8'd1; exp_load_lt1 = 8'd1;
`else
        exp_lt1 = 8'd3; exp_lt2 = 8'd3; exp_load_lt1 = 8'd2;
`endif
        apply_reset();
        set_op(c_alu, 7, 1, 2, 1'b0);
        @(negedge clk);
        set_op(VOP_LOAD_C, 5, 7, 0, 1'b0);
        #1;
        n_vec++; if (m_valid_o !== 1'b1) begin n_err++; $display("FAIL load_m_valid: got %0b exp 1", m_valid_o); end
        n_vec++; if (instr_out.lock !== 2'b11) begin n_err++; $display("FAIL load_lock: got %0d exp 3", instr_out.lock); end
        n_vec++; if (instr_out.ticket !== 8'd2) begin n_err++; $display("FAIL load_ticket: got %0d exp 2", instr_out.ticket); end
        n_vec++; if (m_instr_out.dst !== 7'd33) begin n_err++; $display("FAIL load_m_dst: got %0d exp 33", m_instr_out.dst); end
        n_vec++; if (m_instr_out.src1 !== 7'd32) begin n_err++; $display("FAIL load_m_src1: got %0d exp 32", m_instr_out.src1); end
        n_vec++; if (m_instr_out.last_ticket_src1 !== exp_load_lt1) begin n_err++; $display("FAIL load_last_src1: got %0d exp %0d", m_instr_out.last_ticket_src1, exp_load_lt1); end
        @(negedge clk);
        set_op(VOP_STORE_C, 5, 5, 7, 1'b0);
        m_ready_i = 1'b0;
        #1;
        n_vec++; if (pop_instr !== 1'b0) begin n_err++; $display("FAIL store_mready_stall: got %0b exp 0", pop_instr); end
        n_vec++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL store_mready_mvalid: got %0b exp 0", m_valid_o); end
        m_ready_i = 1'b1;
        #1;
        n_vec++; if (pop_instr !== 1'b1) begin n_err++; $display("FAIL store_pop: got %0b exp 1", pop_instr); end
        n_vec++; if (instr_out.dst !== 7'd33) begin n_err++; $display("FAIL store_dst: got %0d exp 33", instr_out.dst); end
        n_vec++; if (instr_out.dst_iszero !== 1'b1) begin n_err++; $display("FAIL store_dst_iszero: got %0b exp 1", instr_out.dst_iszero); end
        n_vec++; if (instr_out.lock !== 2'b01) begin n_err++; $display("FAIL store_lock: got %0d exp 1", instr_out.lock); end
        n_vec++; if (m_valid_o !== 1'b1) begin n_err++; $display("FAIL store_m_valid: got %0b exp 1", m_valid_o); end
        n_vec++; if (instr_out.src1 !== 7'd33) begin n_err++; $display("FAIL store_src1: got %0d exp 33", instr_out.src1); end
        n_vec++; if (instr_out.src2 !== 7'd32) begin n_err++; $display("FAIL store_src2: got %0d exp 32", instr_out.src2); end
        n_vec++; if (m_instr_out.ticket !== 8'd3) begin n_err++; $display("FAIL store_ticket: got %0d exp 3", m_instr_out.ticket); end
        n_vec++; if (m_instr_out.last_ticket_src1 !== exp_lt1) begin n_err++; $display("FAIL store_last_src1: got %0d exp %0d", m_instr_out.last_ticket_src1, exp_lt1); end
        n_vec++; if (m_instr_out.last_ticket_src2 !== exp_lt2) begin n_err++; $display("FAIL store_last_src2: got %0d exp %0d", m_instr_out.last_ticket_src2, exp_lt2); end
        @(negedge clk);
        set_op(c_alu, 9, 1, 1, 1'b0);
        #1;
        n_vec++; if (instr_out.dst !== 7'd34) begin n_err++; $display("FAIL store_no_alloc: got %0d exp 34", instr_out.dst); end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic test_retire_err();
        apply_reset();
        set_op(c_alu, 3, 1, 2, 1'b0);
        @(negedge clk);
        set_op(c_alu, 4, 1, 2, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        retire_valid_i = 1'b1; retire_ticket_i = 4'd3;
        #1;
        n_vec++; if (retire_err_o !== 1'b0) begin n_err++; $display("FAIL err_before_edge: got %0b exp 0", retire_err_o); end
        @(negedge clk);
        retire_valid_i = 1'b0;
        #1;
        n_vec++; if (retire_err_o !== 1'b1) begin n_err++; $display("FAIL err_set: got %0b exp 1", retire_err_o); end
        n_vec++; if (is_idle_o !== 1'b0) begin n_err++; $display("FAIL err_head_kept: got %0b exp 0", is_idle_o); end
        retire_valid_i = 1'b1; retire_ticket_i = 4'd1;
        @(negedge clk);
        retire_ticket_i = 4'd2;
        @(negedge clk);
        retire_valid_i = 1'b0;
        #1;
        n_vec++; if (retire_err_o !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %0b exp 1", retire_err_o); end
        n_vec++; if (is_idle_o !== 1'b1) begin n_err++; $display("FAIL err_drained_idle: got %0b exp 1", is_idle_o); end
        @(negedge clk);
    endtask

    task automatic test_reconfigure();
        apply_reset();
        set_op(c_alu, 3, 1, 2, 1'b0);
        @(negedge clk);
        set_op(c_alu, 4, 1, 2, 1'b0);
        @(negedge clk);
        set_op(c_alu, 0, 0, 0, 1'b1);
        retire_valid_i = 1'b1; retire_ticket_i = 4'd1;
        #1;
        n_vec++; if (pop_instr !== 1'b0) begin n_err++; $display("FAIL reconf_stall0: got %0b exp 0", pop_instr); end
        @(negedge clk);
        retire_ticket_i = 4'd2;
        #1;
        n_vec++; if (pop_instr !== 1'b0) begin n_err++; $display("FAIL reconf_stall1: got %0b exp 0", pop_instr); end
        @(negedge clk);
        retire_valid_i = 1'b0;
        #1;
        n_vec++; if (pop_instr !== 1'b1) begin n_err++; $display("FAIL reconf_fire: got %0b exp 1", pop_instr); end
        n_vec++; if (instr_out.ticket !== 8'd3) begin n_err++; $display("FAIL reconf_ticket: got %0d exp 3", instr_out.ticket); end
        n_vec++; if (instr_out.lock !== 2'b00) begin n_err++; $display("FAIL reconf_lock: got %0d exp 0", instr_out.lock); end
        @(negedge clk);
        set_op(c_alu, 3, 3, 0, 1'b0);
        #1;
        n_vec++; if (instr_out.ticket !== 8'd1) begin n_err++; $display("FAIL reconf_next_ticket: got %0d exp 1", instr_out.ticket); end
        n_vec++; if (instr_out.dst !== 7'd32) begin n_err++; $display("FAIL reconf_next_dst: got %0d exp 32", instr_out.dst); end
        n_vec++; if (instr_out.src1 !== 7'd3) begin n_err++; $display("FAIL reconf_identity: got %0d exp 3", instr_out.src1); end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_rename();
        test_freelist_empty();
        test_fifo_full();
        test_store_after_load();
        test_retire_err();
        test_reconfigure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
